// File: rtl/load_store_unit.sv
// Memory-access stage: turns load/store codes into word address, byte enables and
// lane-replicated store data, runs a req/ready handshake and returns an extended load result.
module load_store_unit #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          we,
    input  logic [2:0]    load,
    input  logic [1:0]    store,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          misaligned,
    output logic          timeout,
    output logic [31:0]   rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    input  logic [31:0]   mem_rdata,
    output logic [1:0]    dbg_state
);

    // Handshake: mem_req rises on entry to REQ and, with mem_addr/mem_we/mem_be/mem_wdata,
    // holds stable until the first cycle mem_ready=1; that cycle completes the transfer.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_e;
    typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_e;

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_e        state_q;
    logic          we_q;
    logic [2:0]    load_q;
    logic [1:0]    lo_q;
    logic [CW-1:0] wait_cnt_q;
    logic          busy_q, done_q, misaligned_q, timeout_q;
    logic [31:0]   rdata_q;
    logic          mem_req_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [3:0]    mem_be_q;
    logic [31:0]   mem_wdata_q;

    size_e         size_d;
    logic          misalign_d;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;
    logic [31:0]   lane_d;
    logic [31:0]   ext_d;

    // Launch-side decode works on the live inputs, since it is only used in the IDLE start cycle.
    always_comb begin
        size_d = SZ_WORD;
        if (we) begin
            case (store)
                2'b01:   size_d = SZ_HALF;
                2'b10:   size_d = SZ_BYTE;
                default: size_d = SZ_WORD;
            endcase
        end else begin
            case (load)
                3'b001, 3'b011: size_d = SZ_HALF;
                3'b010, 3'b100: size_d = SZ_BYTE;
                default:        size_d = SZ_WORD;
            endcase
        end

        misalign_d = ((size_d == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                     ((size_d == SZ_HALF) && addr[0]);

        be_d    = 4'b1111;
        wdata_d = wdata;
        case (size_d)
            SZ_HALF: begin
                be_d    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wdata[15:0]}};
            end
            SZ_BYTE: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{wdata[7:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = wdata;
            end
        endcase
    end

    always_comb begin
        lane_d = mem_rdata >> {lo_q, 3'b000};
        case (load_q)
            3'b001:  ext_d = {{16{lane_d[15]}}, lane_d[15:0]};
            3'b011:  ext_d = {16'h0000, lane_d[15:0]};
            3'b010:  ext_d = {{24{lane_d[7]}}, lane_d[7:0]};
            3'b100:  ext_d = {24'h000000, lane_d[7:0]};
            default: ext_d = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            load_q       <= 3'b000;
            lo_q         <= 2'b00;
            wait_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            rdata_q      <= 32'h0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        we_q   <= we;
                        load_q <= load;
                        lo_q   <= addr[1:0];
                        busy_q <= 1'b1;
                        if (misalign_d) begin
                            state_q      <= DONE;
                            done_q       <= 1'b1;
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= we;
                            mem_addr_q  <= {addr[AW-1:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                            wait_cnt_q  <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!we_q) rdata_q <= ext_d;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else if ((TIMEOUT != 0) && (wait_cnt_q == CW'(TIMEOUT - 1))) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q       <= 1'b0;
                    misaligned_q <= 1'b0;
                    timeout_q    <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign misaligned = misaligned_q;
    assign timeout    = timeout_q;
    assign rdata      = rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: reset, loads with extension, stores, misalignment,
// timeout with ignored start, and reset in the middle of a request.
module tb_load_store_unit;

    localparam int AW = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic          clk;
    logic          rstn;
    logic          start;
    logic          we;
    logic [2:0]    load;
    logic [1:0]    store;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          busy, done, misaligned, timeout;
    logic [31:0]   rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.AW(AW), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .we         (we),
        .load       (load),
        .store      (store),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned),
        .timeout    (timeout),
        .rdata      (rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one access for a single sampling edge, then drops start.
    task automatic issue(input logic w, input logic [2:0] ld, input logic [1:0] st,
                         input logic [31:0] a, input logic [31:0] d);
        we    = w;
        load  = ld;
        store = st;
        addr  = a;
        wdata = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        start     = 1'b0;
        we        = 1'b0;
        load      = 3'b000;
        store     = 2'b00;
        addr      = '0;
        wdata     = 32'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) tick();

        check("rst_state",   {30'h0, dbg_state}, {30'h0, S_IDLE});
        check("rst_busy",    {31'h0, busy},      32'h0);
        check("rst_done",    {31'h0, done},      32'h0);
        check("rst_mem_req", {31'h0, mem_req},   32'h0);
        check("rst_mem_be",  {28'h0, mem_be},    32'h0);
        check("rst_rdata",   rdata,              32'h0);
        check("rst_addr",    mem_addr,           32'h0);
        #3 rstn = 1'b1;
        tick();

        // LB at 0x1003, zero-wait: byte 3 of 0x80FF1234 is 0x80 -> sign-extended
        issue(1'b0, 3'b010, 2'b00, 32'h0000_1003, 32'h0);
        check("lb_req",      {31'h0, mem_req},   32'h1);
        check("lb_busy",     {31'h0, busy},      32'h1);
        check("lb_addr",     mem_addr,           32'h0000_1000);
        check("lb_be",       {28'h0, mem_be},    32'h8);
        check("lb_we",       {31'h0, mem_we},    32'h0);
        check("lb_done_early", {31'h0, done},    32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'h80FF_1234;
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check("lb_done",     {31'h0, done},      32'h1);
        check("lb_rdata",    rdata,              32'hFFFF_FF80);
        check("lb_mis",      {31'h0, misaligned}, 32'h0);
        check("lb_to",       {31'h0, timeout},   32'h0);
        check("lb_req_off",  {31'h0, mem_req},   32'h0);
        tick();
        check("lb_done_off", {31'h0, done},      32'h0);
        check("lb_idle",     {30'h0, dbg_state}, {30'h0, S_IDLE});

        // LHU at 0x2002: upper half 0x8001, zero-extended
        issue(1'b0, 3'b011, 2'b00, 32'h0000_2002, 32'h0);
        check("lhu_be",      {28'h0, mem_be},    32'hC);
        mem_ready = 1'b1;
        mem_rdata = 32'h8001_0000;
        tick();
        mem_ready = 1'b0;
        check("lhu_rdata",   rdata,              32'h0000_8001);
        tick();

        // LH at 0x2002: same half, sign-extended
        issue(1'b0, 3'b001, 2'b00, 32'h0000_2002, 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'h8001_0000;
        tick();
        mem_ready = 1'b0;
        check("lh_rdata",    rdata,              32'hFFFF_8001);
        tick();

        // LBU at 0x1001: byte 1 of 0x00008000 is 0x80, zero-extended
        issue(1'b0, 3'b100, 2'b00, 32'h0000_1001, 32'h0);
        check("lbu_be",      {28'h0, mem_be},    32'h2);
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_8000;
        tick();
        mem_ready = 1'b0;
        check("lbu_rdata",   rdata,              32'h0000_0080);
        tick();

        // Load code 111 behaves as LW; one wait cycle before ready
        issue(1'b0, 3'b111, 2'b00, 32'h0000_5000, 32'h0);
        check("lw_be",       {28'h0, mem_be},    32'hF);
        tick();
        check("lw_wait_req", {31'h0, mem_req},   32'h1);
        check("lw_wait_done", {31'h0, done},     32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0;
        check("lw_done",     {31'h0, done},      32'h1);
        check("lw_rdata",    rdata,              32'hDEAD_BEEF);
        tick();

        // SB at 0x3001: lane 1 enable, byte replicated, rdata untouched
        issue(1'b1, 3'b000, 2'b10, 32'h0000_3001, 32'h0000_00AB);
        check("sb_req",      {31'h0, mem_req},   32'h1);
        check("sb_we",       {31'h0, mem_we},    32'h1);
        check("sb_addr",     mem_addr,           32'h0000_3000);
        check("sb_be",       {28'h0, mem_be},    32'h2);
        check("sb_wdata",    mem_wdata,          32'hABAB_ABAB);
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_1111;
        tick();
        mem_ready = 1'b0;
        check("sb_done",     {31'h0, done},      32'h1);
        check("sb_rdata_keep", rdata,            32'hDEAD_BEEF);
        tick();

        // SH at 0x3002: upper lanes, half replicated
        issue(1'b1, 3'b000, 2'b01, 32'h0000_3002, 32'h1234_CDEF);
        check("sh_be",       {28'h0, mem_be},    32'hC);
        check("sh_wdata",    mem_wdata,          32'hCDEF_CDEF);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();

        // SW at 0x4002: misaligned, completes at start+1 without a request
        issue(1'b1, 3'b000, 2'b00, 32'h0000_4002, 32'h5555_5555);
        check("sw_mis_req",  {31'h0, mem_req},   32'h0);
        check("sw_mis_done", {31'h0, done},      32'h1);
        check("sw_mis_flag", {31'h0, misaligned}, 32'h1);
        check("sw_mis_to",   {31'h0, timeout},   32'h0);
        tick();
        check("sw_mis_clr",  {31'h0, misaligned}, 32'h0);
        check("sw_mis_idle", {30'h0, dbg_state}, {30'h0, S_IDLE});
        check("sw_mis_rdata", rdata,             32'hDEAD_BEEF);

        // LW with no ready: four wait cycles then timeout; start during REQ ignored
        mem_rdata = 32'h9999_9999;
        issue(1'b0, 3'b000, 2'b00, 32'h0000_6000, 32'h0);
        check("to_req1",     {31'h0, mem_req},   32'h1);
        we    = 1'b1;
        addr  = 32'h0000_7770;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_req2",     {31'h0, mem_req},   32'h1);
        check("to_addr_hold", mem_addr,          32'h0000_6000);
        check("to_we_hold",  {31'h0, mem_we},    32'h0);
        tick();
        check("to_req3",     {31'h0, mem_req},   32'h1);
        tick();
        check("to_req4",     {31'h0, mem_req},   32'h1);
        check("to_not_done", {31'h0, done},      32'h0);
        tick();
        check("to_done",     {31'h0, done},      32'h1);
        check("to_flag",     {31'h0, timeout},   32'h1);
        check("to_req_off",  {31'h0, mem_req},   32'h0);
        check("to_rdata",    rdata,              32'hDEAD_BEEF);
        tick();
        check("to_clr",      {31'h0, timeout},   32'h0);
        check("to_idle",     {30'h0, dbg_state}, {30'h0, S_IDLE});
        tick();
        check("to_ign_req",  {31'h0, mem_req},   32'h0);

        // Reset asserted mid-REQ drops the request at once
        issue(1'b0, 3'b000, 2'b00, 32'h0000_7000, 32'h0);
        check("rr_req",      {31'h0, mem_req},   32'h1);
        #2 rstn = 1'b0;
        #1;
        check("rr_req_off",  {31'h0, mem_req},   32'h0);
        check("rr_busy",     {31'h0, busy},      32'h0);
        check("rr_state",    {30'h0, dbg_state}, {30'h0, S_IDLE});
        check("rr_rdata",    rdata,              32'h0);
        mem_ready = 1'b1;
        tick();
        check("rr_no_done1", {31'h0, done},      32'h0);
        #3 rstn = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("rr_no_done2", {31'h0, done},      32'h0);
        check("rr_idle",     {30'h0, dbg_state}, {30'h0, S_IDLE});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
